addsub_serial: RTL and testbench

- Parametrised, multi-cycle add/subtract unit. It processes DIGIT bits per clock, starting from the LSB.
- It replaces fixed 8-bit ripple subtractors wherever WIDTH-bit add or subtract is needed without a full-width combinational carry/borrow chain.
- A start/busy/done handshake moves operands in and results out, which lets a controlling FSM share one unit across several operations.

---
 rtl/addsub_pkg.sv | 24 ++
 rtl/addsub_serial_digit.sv | 30 +++
 rtl/addsub_serial.sv | 109 ++++++++++
 tb/tb_addsub_serial.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types and helpers for the digit-serial add/subtract unit.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic logic calc_ov(
        input logic i_mode,
        input logic i_a_msb,
        input logic i_b_msb,
        input logic i_s_msb
    );
        if (i_mode == MODE_SUB)
            return (i_a_msb != i_b_msb) && (i_s_msb != i_a_msb);
        return (i_a_msb == i_b_msb) && (i_s_msb != i_a_msb);
    endfunction

endpackage

// File: rtl/addsub_serial_digit.sv
// DIGIT-bit ripple slice; sub mode propagates a true borrow.
module digit_addsub
    import addsub_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    input  logic             mode,
    output logic [DIGIT-1:0] d,
    output logic             cout
);

    logic [DIGIT:0] w_c;

    assign w_c[0] = cin;
    assign cout   = w_c[DIGIT];

    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_bit
        logic w_carry;
        logic w_borrow;

        assign d[gi]     = x[gi] ^ y[gi] ^ w_c[gi];
        assign w_carry   = (x[gi] & y[gi]) | (w_c[gi] & (x[gi] ^ y[gi]));
        assign w_borrow  = (~x[gi] & (y[gi] | w_c[gi])) | (y[gi] & w_c[gi]);
        assign w_c[gi+1] = (mode == MODE_SUB) ? w_borrow : w_carry;
    end

endmodule

// File: rtl/addsub_serial.sv
// Multi-cycle add/subtract: DIGIT bits per RUN cycle, LSB first,
// with a start/busy/done handshake.
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ov
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_mode;
    logic             r_chain;
    logic [WIDTH-1:0] r_s;
    logic             r_co;
    logic             r_ov;

    logic [DIGIT-1:0] w_d;
    logic             w_cout;
    logic             w_last;
    logic             w_accept;

    assign w_last   = (r_cnt == CW'(N - 1));
    assign w_accept = start && (r_state != RUN);

    digit_addsub #(.DIGIT(DIGIT)) u_slice (
        .x    (r_a[DIGIT-1:0]),
        .y    (r_b[DIGIT-1:0]),
        .cin  (r_chain),
        .mode (r_mode),
        .d    (w_d),
        .cout (w_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (w_last) w_next = DONE;
            DONE:    w_next = start ? RUN : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == RUN);
        done = (r_state == DONE);
    end

    // Operands shift right so the slice always sees the current digit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_mode  <= MODE_ADD;
            r_chain <= 1'b0;
            r_s     <= '0;
            r_co    <= 1'b0;
            r_ov    <= 1'b0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_a     <= a;
            r_b     <= b;
            r_mode  <= mode;
            r_chain <= ci;
        end else if (r_state == RUN) begin
            r_s[32'(r_cnt) * DIGIT +: DIGIT] <= w_d;
            r_chain <= w_cout;
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                r_co <= w_cout;
                r_ov <= calc_ov(r_mode, r_a[DIGIT-1],
                                r_b[DIGIT-1], w_d[DIGIT-1]);
            end
        end
    end

    assign s  = r_s;
    assign co = r_co;
    assign ov = r_ov;

endmodule

// File: tb/tb_addsub_serial.sv
// Scoreboard bench: directed 16/4 checks plus random sweeps over
// several WIDTH/DIGIT combinations.
module tb_addsub_serial;

    typedef struct packed {
        logic [31:0] s;
        logic        co;
        logic        ov;
    } exp_t;

    int n_tests = 0;
    int n_fail  = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference built from integer arithmetic, independent of the slice logic
    function automatic exp_t model(input int w, input logic m,
                                   input logic [31:0] a,
                                   input logic [31:0] b,
                                   input logic c);
        longint ua, ub, uc, ur, sa, sb, sr, lim;
        exp_t e;
        ua  = longint'(a);
        ub  = longint'(b);
        uc  = c ? 64'sd1 : 64'sd0;
        lim = 64'sd1 <<< (w - 1);
        sa  = (ua >= lim) ? ua - 2 * lim : ua;
        sb  = (ub >= lim) ? ub - 2 * lim : ub;
        if (m) begin
            ur   = ua - ub - uc;
            sr   = sa - sb - uc;
            e.co = (ua < ub + uc);
        end else begin
            ur   = ua + ub + uc;
            sr   = sa + sb + uc;
            e.co = (ur >= 2 * lim);
        end
        ur   = ur & (2 * lim - 1);
        e.s  = 32'(ur);
        e.ov = (sr < -lim) || (sr >= lim);
        return e;
    endfunction

    localparam int W = 16;
    localparam int D = 4;
    localparam int N = W / D;

    logic         rst, start, mode, ci;
    logic [W-1:0] a, b;
    logic         busy, done, co, ov;
    logic [W-1:0] s;

    addsub_serial #(.WIDTH(W), .DIGIT(D)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .mode  (mode),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .co    (co),
        .ov    (ov)
    );

    exp_t q[$];

    initial begin
        int bcnt;
        exp_t e;
        bcnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bcnt = 0;
            end else if (busy) begin
                bcnt++;
            end else if (done) begin
                if (q.size() == 0) begin
                    chk("spurious_done", 32'(done), 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("s", 32'(s), e.s);
                    chk("co", 32'(co), 32'(e.co));
                    chk("ov", 32'(ov), 32'(e.ov));
                    chk("busy_len", 32'(bcnt), 32'(N));
                end
                bcnt = 0;
            end
        end
    end

    task automatic wait_done(input string tag);
        int t;
        t = 0;
        while (!done && t < 4 * N + 8) begin
            @(negedge clk);
            t++;
        end
        if (!done) chk(tag, 32'(done), 32'd1);
    endtask

    task automatic launch(input logic m, input logic [W-1:0] xa,
                          input logic [W-1:0] xb, input logic c);
        mode  = m;
        a     = xa;
        b     = xb;
        ci    = c;
        q.push_back(model(W, m, 32'(xa), 32'(xb), c));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_op(input logic m, input logic [W-1:0] xa,
                          input logic [W-1:0] xb, input logic c);
        launch(m, xa, xb, c);
        wait_done("op_timeout");
        @(negedge clk);
    endtask

    localparam int SW_W [4] = '{8, 8, 8, 16};
    localparam int SW_D [4] = '{1, 2, 8, 16};

    for (genvar g = 0; g < 4; g++) begin : g_sw
        localparam int WW = SW_W[g];
        localparam int DD = SW_D[g];
        localparam int NN = WW / DD;

        logic          sr, st, sm, sc;
        logic [WW-1:0] sa, sb;
        logic          sbusy, sdone, sco, sov;
        logic [WW-1:0] ss;
        bit            fin = 1'b0;
        exp_t          sq[$];

        addsub_serial #(.WIDTH(WW), .DIGIT(DD)) u_sw (
            .clk   (clk),
            .rst   (sr),
            .start (st),
            .mode  (sm),
            .a     (sa),
            .b     (sb),
            .ci    (sc),
            .busy  (sbusy),
            .done  (sdone),
            .s     (ss),
            .co    (sco),
            .ov    (sov)
        );

        initial begin
            int bc;
            exp_t e;
            bc = 0;
            forever begin
                @(negedge clk);
                if (sr) begin
                    bc = 0;
                end else if (sbusy) begin
                    bc++;
                end else if (sdone) begin
                    if (sq.size() == 0) begin
                        chk("sw_spurious", 32'(sdone), 32'd0);
                    end else begin
                        e = sq.pop_front();
                        chk("sw_s", 32'(ss), e.s);
                        chk("sw_co", 32'(sco), 32'(e.co));
                        chk("sw_ov", 32'(sov), 32'(e.ov));
                        chk("sw_busy_len", 32'(bc), 32'(NN));
                    end
                    bc = 0;
                end
            end
        end

        initial begin
            sr = 1'b1;
            st = 1'b0;
            sm = 1'b0;
            sc = 1'b0;
            sa = '0;
            sb = '0;
            repeat (2) @(negedge clk);
            sr = 1'b0;
            for (int i = 0; i < 30; i++) begin
                int t;
                sa = WW'($urandom);
                sb = WW'($urandom);
                sc = 1'($urandom);
                sm = 1'($urandom);
                sq.push_back(model(WW, sm, 32'(sa), 32'(sb), sc));
                st = 1'b1;
                @(negedge clk);
                st = 1'b0;
                t  = 0;
                while (!sdone && t < 2 * NN + 8) begin
                    @(negedge clk);
                    t++;
                end
                if (!sdone) chk("sw_timeout", 32'(sdone), 32'd1);
            end
            repeat (NN + 4) @(negedge clk);
            chk("sw_q_empty", 32'(sq.size()), 32'd0);
            fin = 1'b1;
        end
    end

    initial begin
        int t;
        rst   = 1'b1;
        start = 1'b1;
        mode  = 1'b0;
        a     = 16'h1234;
        b     = 16'h0FCD;
        ci    = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_s", 32'(s), 32'd0);
        chk("rst_co", 32'(co), 32'd0);
        chk("rst_ov", 32'(ov), 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("rst_no_op", 32'(busy), 32'd0);

        run_op(1'b0, 16'h1234, 16'h0FCD, 1'b0);
        run_op(1'b1, 16'h0005, 16'h0007, 1'b1);
        run_op(1'b0, 16'h7FFF, 16'h0001, 1'b0);
        run_op(1'b1, 16'h8000, 16'h0001, 1'b0);
        run_op(1'b0, 16'hFFFF, 16'hFFFF, 1'b1);

        // start held high through the whole RUN phase
        mode  = 1'b0;
        a     = 16'h00F0;
        b     = 16'h0F0F;
        ci    = 1'b0;
        q.push_back(model(W, 1'b0, 32'h00F0, 32'h0F0F, 1'b0));
        start = 1'b1;
        repeat (N + 1) @(negedge clk);
        chk("held_done", 32'(done), 32'd1);
        start = 1'b0;
        @(negedge clk);
        chk("held_ignored", 32'(busy), 32'd0);
        @(negedge clk);

        // back-to-back start issued in the DONE cycle
        launch(1'b1, 16'h0005, 16'h0007, 1'b1);
        wait_done("b2b_timeout");
        mode  = 1'b0;
        a     = 16'h0001;
        b     = 16'h0001;
        ci    = 1'b0;
        q.push_back(model(W, 1'b0, 32'h1, 32'h1, 1'b0));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_hold_s", 32'(s), 32'hFFFD);
        chk("b2b_hold_co", 32'(co), 32'd1);
        chk("b2b_hold_ov", 32'(ov), 32'd0);
        wait_done("b2b2_timeout");
        @(negedge clk);

        // reset during RUN digit 2 abandons the operation
        mode  = 1'b0;
        a     = 16'hFFFF;
        b     = 16'h0001;
        ci    = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_s", 32'(s), 32'd0);
        chk("mid_rst_co", 32'(co), 32'd0);
        chk("mid_rst_ov", 32'(ov), 32'd0);
        repeat (N + 3) @(negedge clk);
        chk("mid_rst_idle", 32'(busy), 32'd0);
        chk("q_empty", 32'(q.size()), 32'd0);

        t = 0;
        while (!(g_sw[0].fin && g_sw[1].fin && g_sw[2].fin && g_sw[3].fin)
               && t < 20000) begin
            @(negedge clk);
            t++;
        end
        chk("sweep_fin",
            32'({g_sw[3].fin, g_sw[2].fin, g_sw[1].fin, g_sw[0].fin}),
            32'hF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
